// File: rtl/serial_sub_pkg.sv
// Shared types and helpers for the bit-serial subtractor controller.
package serial_sub_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int unsigned DEF_WIDTH = 8;

   // Bit counter width for a given operand width; floor of 1 keeps the vector legal.
   function automatic int unsigned cnt_width(input int unsigned w);
      return (w < 2) ? 1 : $clog2(w);
   endfunction

endpackage

// File: rtl/full_subtractor.sv
// Single 1-bit full-subtractor cell: diff = a - b - bin, with borrow out.
module full_subtractor (
   input  logic a,
   input  logic b,
   input  logic bin,
   output logic diff,
   output logic bout
);

   assign diff = a ^ b ^ bin;
   assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_sub_ctrl.sv
// Bit-serial WIDTH-bit subtractor: LSB-first through one shared cell, borrow chained in a flop.
module serial_sub_ctrl
   import serial_sub_pkg::*;
#(
   parameter int unsigned WIDTH = DEF_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             borrow
);

   localparam int unsigned CW = cnt_width(WIDTH);

   state_t           state;
   logic [WIDTH-1:0] sa;
   logic [WIDTH-1:0] sb;
   logic [WIDTH-1:0] wr;
   logic             bf;
   logic [CW-1:0]    cnt;
   logic             cell_d;
   logic             cell_bout;

   full_subtractor u_cell (
      .a    (sa[0]),
      .b    (sb[0]),
      .bin  (bf),
      .diff (cell_d),
      .bout (cell_bout)
   );

   // Sequencer: operand capture, per-bit shifting and result/handshake registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         sa     <= '0;
         sb     <= '0;
         wr     <= '0;
         bf     <= 1'b0;
         cnt    <= '0;
         busy   <= 1'b0;
         done   <= 1'b0;
         diff   <= '0;
         borrow <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  sa    <= a;
                  sb    <= b;
                  bf    <= 1'b0;
                  cnt   <= '0;
                  busy  <= 1'b1;
                  state <= RUN;
               end
            end
            RUN: begin
               bf <= cell_bout;
               sa <= sa >> 1;
               sb <= sb >> 1;
               wr <= {cell_d, wr[WIDTH-1:1]};
               if (cnt == CW'(WIDTH - 1)) begin
                  diff   <= {cell_d, wr[WIDTH-1:1]};
                  borrow <= cell_bout;
                  busy   <= 1'b0;
                  done   <= 1'b1;
                  state  <= DONE;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            DONE: begin
               done  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               busy  <= 1'b0;
               done  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Directed, table-driven bench for serial_sub_ctrl at WIDTH=8 and WIDTH=2.
module tb_serial_sub_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start8, start2;
   logic [7:0] a8, b8, diff8;
   logic [1:0] a2, b2, diff2;
   logic       busy8, done8, borrow8;
   logic       busy2, done2, borrow2;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   serial_sub_ctrl #(.WIDTH(8)) dut8 (
      .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8),
      .busy(busy8), .done(done8), .diff(diff8), .borrow(borrow8)
   );

   serial_sub_ctrl #(.WIDTH(2)) dut2 (
      .clk(clk), .rst_n(rst_n), .start(start2), .a(a2), .b(b2),
      .busy(busy2), .done(done2), .diff(diff2), .borrow(borrow2)
   );

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] diff;
      logic       borrow;
   } vec_t;

   vec_t vecs [6];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   // Accept one 8-bit op, check busy window, done pulse, result and return to idle.
   task automatic run_op8(input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] ed, input logic eb);
      @(negedge clk);
      start8 = 1'b1; a8 = a; b8 = b;
      @(negedge clk);
      start8 = 1'b0;
      for (int i = 0; i < 8; i++) begin
         check("busy8_run", 32'(busy8), 32'd1);
         check("done8_run", 32'(done8), 32'd0);
         @(negedge clk);
      end
      check("done8_pulse", 32'(done8), 32'd1);
      check("busy8_done", 32'(busy8), 32'd0);
      check("diff8", 32'(diff8), 32'(ed));
      check("borrow8", 32'(borrow8), 32'(eb));
      @(negedge clk);
      check("done8_single", 32'(done8), 32'd0);
      check("busy8_idle", 32'(busy8), 32'd0);
   endtask

   task automatic run_op2(input logic [1:0] a, input logic [1:0] b);
      logic [1:0] ed;
      logic       eb;
      ed = 2'(a - b);
      eb = (a < b);
      @(negedge clk);
      start2 = 1'b1; a2 = a; b2 = b;
      @(negedge clk);
      start2 = 1'b0;
      for (int i = 0; i < 2; i++) begin
         check("busy2_run", 32'(busy2), 32'd1);
         @(negedge clk);
      end
      check("done2_pulse", 32'(done2), 32'd1);
      check("diff2", 32'(diff2), 32'(ed));
      check("borrow2", 32'(borrow2), 32'(eb));
      @(negedge clk);
   endtask

   initial begin
      logic [7:0] seq_a [3];
      logic [7:0] seq_b [3];
      logic [7:0] seq_d [3];
      int         k;
      int         last_done;
      int         dcount;

      vecs[0] = '{8'h5A, 8'h3C, 8'h1E, 1'b0};
      vecs[1] = '{8'h00, 8'h01, 8'hFF, 1'b1};
      vecs[2] = '{8'hFF, 8'hFF, 8'h00, 1'b0};
      vecs[3] = '{8'h01, 8'h80, 8'h81, 1'b1};
      vecs[4] = '{8'hC3, 8'h42, 8'h81, 1'b0};
      vecs[5] = '{8'h7F, 8'h80, 8'hFF, 1'b1};

      rst_n = 1'b0; start8 = 1'b0; start2 = 1'b0;
      a8 = '0; b8 = '0; a2 = '0; b2 = '0;
      #12;
      check("rst_busy", 32'(busy8), 32'd0);
      check("rst_done", 32'(done8), 32'd0);
      check("rst_diff", 32'(diff8), 32'd0);
      check("rst_borrow", 32'(borrow8), 32'd0);
      #11 rst_n = 1'b1;

      for (int i = 0; i < 6; i++)
         run_op8(vecs[i].a, vecs[i].b, vecs[i].diff, vecs[i].borrow);

      // Start re-pulsed during RUN and DONE must be ignored.
      @(negedge clk);
      start8 = 1'b1; a8 = 8'h5A; b8 = 8'h3C;
      @(negedge clk);
      start8 = 1'b0;
      @(negedge clk);
      @(negedge clk);
      start8 = 1'b1; a8 = 8'h10; b8 = 8'h01;
      @(negedge clk);
      start8 = 1'b0;
      dcount = 0;
      for (int i = 0; i < 5; i++) begin
         if (done8) dcount++;
         @(negedge clk);
      end
      check("ign_done_seen", 32'(done8), 32'd1);
      check("ign_diff", 32'(diff8), 32'h1E);
      check("ign_borrow", 32'(borrow8), 32'd0);
      start8 = 1'b1;
      @(negedge clk);
      start8 = 1'b0;
      for (int i = 0; i < 12; i++) begin
         if (done8) dcount++;
         check("ign_busy_idle", 32'(busy8), 32'd0);
         @(negedge clk);
      end
      check("ign_done_count", 32'(dcount), 32'd0);

      // Reset mid-RUN aborts immediately with no later done pulse.
      start8 = 1'b1; a8 = 8'h5A; b8 = 8'h3C;
      @(negedge clk);
      start8 = 1'b0;
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      check("pre_rst_busy", 32'(busy8), 32'd1);
      rst_n = 1'b0;
      #1;
      check("mid_rst_busy", 32'(busy8), 32'd0);
      check("mid_rst_done", 32'(done8), 32'd0);
      check("mid_rst_diff", 32'(diff8), 32'd0);
      check("mid_rst_borrow", 32'(borrow8), 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      dcount = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (done8 || busy8) dcount++;
      end
      check("post_rst_quiet", 32'(dcount), 32'd0);
      run_op8(8'h80, 8'h01, 8'h7F, 1'b0);

      // Start held high: three back-to-back ops, done every WIDTH+2 cycles.
      seq_a = '{8'h5A, 8'h00, 8'h20};
      seq_b = '{8'h3C, 8'h01, 8'h05};
      seq_d = '{8'h1E, 8'hFF, 8'h1B};
      k = 0;
      last_done = 0;
      @(negedge clk);
      start8 = 1'b1; a8 = seq_a[0]; b8 = seq_b[0];
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         check("busy_done_excl", 32'(busy8 & done8), 32'd0);
         if (done8) begin
            check("hold_diff", 32'(diff8), 32'(seq_d[k]));
            if (k > 0) check("hold_gap", 32'(c - last_done), 32'd10);
            last_done = c;
            k++;
            if (k < 3) begin
               a8 = seq_a[k]; b8 = seq_b[k];
            end else begin
               start8 = 1'b0;
            end
         end else if (busy8 && k > 0) begin
            check("hold_stable", 32'(diff8), 32'(seq_d[k-1]));
         end
      end
      start8 = 1'b0;
      check("hold_count", 32'(k), 32'd3);

      // Exhaustive WIDTH=2 against the behavioural model.
      for (int x = 0; x < 4; x++)
         for (int y = 0; y < 4; y++)
            run_op2(2'(x), 2'(y));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
